// File: rtl/multicycle_alu_chunked.sv
// Multi-cycle integer ALU (ADD/SUB/AND/XOR) that ripples CHUNK bits per cycle
// through a registered inter-chunk carry, with valid/ready handshakes on both sides.
module multicycle_alu_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] OP_SUB = 2'b01;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_eff_q, b_eff_d;
    logic [1:0]        op_q, op_d;
    logic [KW-1:0]     k_q, k_d;
    logic              creg_q, creg_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk, logic_chunk;
    logic [CHUNK:0]    sum_chunk;
    logic [WIDTH-1:0]  new_result;
    logic              is_arith;

    // b_eff equals b for AND/XOR, so one operand register serves every op.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_eff_d    = b_eff_q;
        op_d       = op_q;
        k_d        = k_q;
        creg_d     = creg_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        is_arith    = ~op_q[1];
        a_chunk     = a_q[int'(k_q)*CHUNK +: CHUNK];
        b_chunk     = b_eff_q[int'(k_q)*CHUNK +: CHUNK];
        sum_chunk   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, creg_q};
        logic_chunk = op_q[0] ? (a_chunk ^ b_chunk) : (a_chunk & b_chunk);
        new_result  = result_q;
        new_result[int'(k_q)*CHUNK +: CHUNK] = is_arith ? sum_chunk[CHUNK-1:0] : logic_chunk;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    op_d    = op;
                    b_eff_d = (op == OP_SUB) ? ~b : b;
                    creg_d  = (op == OP_SUB);
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d = new_result;
                creg_d   = is_arith & sum_chunk[CHUNK];
                k_d      = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    // Final chunk: flags are resolved from the fully assembled result.
                    k_d        = '0;
                    state_d    = S_DONE;
                    carry_d    = is_arith & sum_chunk[CHUNK];
                    overflow_d = is_arith & (a_q[WIDTH-1] == b_eff_q[WIDTH-1])
                                 & (new_result[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d     = (new_result == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_eff_q    <= '0;
            op_q       <= '0;
            k_q        <= '0;
            creg_q     <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_eff_q    <= b_eff_d;
            op_q       <= op_d;
            k_q        <= k_d;
            creg_q     <= creg_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_multicycle_alu_chunked.sv
// Directed bench for multicycle_alu_chunked: one instance with CHUNK=8 and one
// with CHUNK=32 share operands; each is started through its own in_valid.
module tb_multicycle_alu_chunked;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid_v;
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        out_ready;
    logic [1:0]  in_ready_v, out_valid_v, carry_v, overflow_v, zero_v;
    logic [31:0] result_v [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_alu_chunked #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .op(op), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .result(result_v[0]), .carry(carry_v[0]), .overflow(overflow_v[0]), .zero(zero_v[0])
    );

    multicycle_alu_chunked #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .op(op), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .result(result_v[1]), .carry(carry_v[1]), .overflow(overflow_v[1]), .zero(zero_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (!out_valid_v[sel] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input int sel, input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                          input logic ec, input logic ev, input logic ez, input int elat);
        int cyc;
        check({tag, ":in_ready"}, 32'(in_ready_v[sel]), 32'd1);
        a = x; b = y; op = o;
        in_valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid_v = '0;
        // Scramble operands while busy: the DUT must have latched them.
        a = $urandom; b = $urandom; op = 2'($urandom_range(3));
        wait_done(sel, cyc);
        check({tag, ":latency"}, 32'(cyc), 32'(elat));
        check({tag, ":result"}, result_v[sel], er);
        check({tag, ":carry"}, 32'(carry_v[sel]), 32'(ec));
        check({tag, ":overflow"}, 32'(overflow_v[sel]), 32'(ev));
        check({tag, ":zero"}, 32'(zero_v[sel]), 32'(ez));
        $display("txn %s op=%0d a=0x%08h b=0x%08h -> result=0x%08h c=%0b v=%0b z=%0b lat=%0d",
                 tag, o, x, y, result_v[sel], carry_v[sel], overflow_v[sel], zero_v[sel], cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":out_valid_clr"}, 32'(out_valid_v[sel]), 32'd0);
        check({tag, ":in_ready_ret"}, 32'(in_ready_v[sel]), 32'd1);
    endtask

    task automatic suite(input int sel, input int lat);
        string p;
        p = (sel == 0) ? "c8" : "c32";
        run_op(sel, {p, "_add_ovf"},  2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, lat);
        run_op(sel, {p, "_add_wrap"}, 2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, lat);
        run_op(sel, {p, "_sub_eq"},   2'b01, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, lat);
        run_op(sel, {p, "_sub_brw"},  2'b01, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, lat);
        run_op(sel, {p, "_sub_ovf"},  2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, lat);
        run_op(sel, {p, "_xor"},      2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, lat);
        run_op(sel, {p, "_and"},      2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, lat);
        run_op(sel, {p, "_and_zero"}, 2'b10, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b0, 1'b0, 1'b1, lat);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid_v = '0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst:in_ready",  32'(in_ready_v[s]),  32'd1);
            check("rst:out_valid", 32'(out_valid_v[s]), 32'd0);
            check("rst:result",    result_v[s],         32'd0);
            check("rst:flags",     32'({carry_v[s], overflow_v[s], zero_v[s]}), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        suite(0, 4);

        // Backpressure: result held, new requests ignored while DONE.
        a = 32'd1; b = 32'd2; op = 2'b00; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        wait_done(0, cyc);
        check("bp:latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid_v[0] = 1'b1; a = 32'd100 + 32'(i); b = 32'd7; op = 2'b11;
            check("bp:result",    result_v[0],         32'd3);
            check("bp:out_valid", 32'(out_valid_v[0]), 32'd1);
            check("bp:in_ready",  32'(in_ready_v[0]),  32'd0);
            @(posedge clk); #1;
        end
        in_valid_v[0] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp:out_valid_clr", 32'(out_valid_v[0]), 32'd0);
        check("bp:in_ready_ret",  32'(in_ready_v[0]),  32'd1);
        @(posedge clk); #1;
        check("bp:no_stray_op",   32'(in_ready_v[0]),  32'd1);
        $display("txn bp held result=0x%08h for 5 cycles", result_v[0]);

        // Reset two cycles into RUN.
        a = 32'd10; b = 32'd20; op = 2'b00; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rstrun:out_valid", 32'(out_valid_v[0]), 32'd0);
        check("rstrun:in_ready",  32'(in_ready_v[0]),  32'd1);
        check("rstrun:result",    result_v[0],         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstrun:out_valid_after", 32'(out_valid_v[0]), 32'd0);
        $display("txn reset mid-run aborted");
        run_op(0, "rstrun_add", 2'b00, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 4);

        suite(1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
